// File: rtl/elevator_if.sv
// Scheduler <-> car signal bundle: call inputs, car status, and the registered
// command/status outputs of the scheduler.
interface elevator_if #(
    parameter int N_FLOORS   = 4,
    parameter int FLOOR_BITS = $clog2(N_FLOORS)
);
    logic [N_FLOORS-1:0]   call_req;
    logic [FLOOR_BITS-1:0] cur_floor;
    logic                  doors_open;
    logic                  served_pulse;
    logic [1:0]            command;
    logic [N_FLOORS-1:0]   pending;
    logic                  dir_up;
    logic                  busy;
    logic                  fault;

    modport master (
        input  call_req, cur_floor, doors_open, served_pulse,
        output command, pending, dir_up, busy, fault
    );

    modport slave (
        output call_req, cur_floor, doors_open, served_pulse,
        input  command, pending, dir_up, busy, fault
    );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN-policy elevator scheduler: latches floor calls, steers one car up/down,
// serves called floors and trips a sticky fault when a move stalls.
module elevator_scheduler #(
    parameter int N_FLOORS       = 4,
    parameter int FLOOR_BITS     = $clog2(N_FLOORS),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    elevator_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_UP    = 2'b01;
    localparam logic [1:0] CMD_DOWN  = 2'b10;
    localparam logic [1:0] CMD_SERVE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_SERVE,
        S_FAULT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FLOOR_BITS-1:0] floor_q, floor_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d;
    logic                  dir_up_q, dir_up_d;
    logic [1:0]            command_q, command_d;
    logic                  busy_q, busy_d;
    logic                  fault_q, fault_d;

    logic                  floor_chg;
    logic                  above;
    logic                  below;
    logic                  here;
    logic [N_FLOORS-1:0]   clr_mask;

    assign floor_chg = (bus.cur_floor != floor_q);
    assign floor_d   = bus.cur_floor;

    // Call bookkeeping; a serve completion beats a same-cycle call on that floor.
    always_comb begin
        above    = 1'b0;
        below    = 1'b0;
        here     = 1'b0;
        clr_mask = '0;
        for (int f = 0; f < N_FLOORS; f++) begin
            if (pending_q[f]) begin
                if (f > int'(bus.cur_floor)) above = 1'b1;
                if (f < int'(bus.cur_floor)) below = 1'b1;
                if (f == int'(bus.cur_floor)) here = 1'b1;
            end
            if (bus.served_pulse && (f == int'(bus.cur_floor))) clr_mask[f] = 1'b1;
        end
        pending_d = (pending_q | bus.call_req) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            floor_q   <= '0;
            pending_q <= '0;
            dir_up_q  <= 1'b1;
            command_q <= CMD_IDLE;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
            command_q <= command_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.doors_open) begin
                    state_d = S_IDLE;
                end else if (here) begin
                    state_d = S_SERVE;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = S_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = S_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            S_UP: begin
                if (floor_chg) begin
                    if (here) begin
                        state_d = S_SERVE;
                    end else if (above) begin
                        state_d = S_UP;
                    end else if (below) begin
                        state_d  = S_DOWN;
                        dir_up_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DOWN: begin
                if (floor_chg) begin
                    if (here) begin
                        state_d = S_SERVE;
                    end else if (below) begin
                        state_d = S_DOWN;
                    end else if (above) begin
                        state_d  = S_UP;
                        dir_up_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SERVE: begin
                if (bus.served_pulse) state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs follow the next state so each transition edge carries its command.
    always_comb begin
        command_d = CMD_IDLE;
        unique case (state_d)
            S_UP:    command_d = CMD_UP;
            S_DOWN:  command_d = CMD_DOWN;
            S_SERVE: command_d = CMD_SERVE;
            default: command_d = CMD_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        fault_d = (state_d == S_FAULT);
    end

    assign bus.command = command_q;
    assign bus.pending = pending_q;
    assign bus.dir_up  = dir_up_q;
    assign bus.busy    = busy_q;
    assign bus.fault   = fault_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a simple car model: a move takes
// 5 held cycles per floor, a serve completes after 4 door cycles.
module tb_elevator_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   car_auto;
    int   mv_cnt;
    int   door_cnt;

    always #5 clk = ~clk;

    elevator_if #(.N_FLOORS(4), .FLOOR_BITS(2)) bus();

    elevator_scheduler #(
        .N_FLOORS(4),
        .FLOOR_BITS(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the car then reacts to the freshly registered command.
    task automatic tick();
        @(posedge clk);
        #1;
        if (car_auto) begin
            case (bus.command)
                2'b01: begin
                    door_cnt = 0; bus.doors_open = 1'b0; bus.served_pulse = 1'b0;
                    mv_cnt++;
                    if (mv_cnt == 5) begin bus.cur_floor = bus.cur_floor + 2'd1; mv_cnt = 0; end
                end
                2'b10: begin
                    door_cnt = 0; bus.doors_open = 1'b0; bus.served_pulse = 1'b0;
                    mv_cnt++;
                    if (mv_cnt == 5) begin bus.cur_floor = bus.cur_floor - 2'd1; mv_cnt = 0; end
                end
                2'b11: begin
                    mv_cnt = 0;
                    bus.doors_open = 1'b1;
                    door_cnt++;
                    if (door_cnt == 4) begin bus.served_pulse = 1'b1; door_cnt = 0; end
                end
                default: begin
                    mv_cnt = 0; door_cnt = 0;
                    bus.doors_open = 1'b0; bus.served_pulse = 1'b0;
                end
            endcase
        end
    endtask

    task automatic call(input logic [3:0] c);
        bus.call_req = c;
        tick();
        bus.call_req = 4'b0000;
    endtask

    task automatic run_until(input logic [1:0] cmd, input string tag);
        int n = 0;
        while (bus.command !== cmd && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.command), 32'(cmd));
    endtask

    task automatic do_reset(input logic [1:0] floor);
        rst_n = 1'b0;
        bus.call_req = 4'b0000;
        bus.served_pulse = 1'b0;
        bus.doors_open = 1'b0;
        bus.cur_floor = floor;
        mv_cnt = 0;
        door_cnt = 0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Test 1: single call two floors up.
        car_auto = 1'b1;
        do_reset(2'd0);
        chk("rst_command", 32'(bus.command), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_dir_up",  32'(bus.dir_up),  32'h1);
        chk("rst_fault",   32'(bus.fault),   32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        call(4'b0100);
        chk("t1_latched",  32'(bus.pending), 32'h4);
        chk("t1_cmd_wait", 32'(bus.command), 32'h0);
        tick();
        chk("t1_latency_up", 32'(bus.command), 32'h1);
        chk("t1_busy",       32'(bus.busy),    32'h1);
        run_until(2'b11, "t1_serve");
        chk("t1_serve_floor", 32'(bus.cur_floor), 32'h2);
        run_until(2'b00, "t1_done");
        chk("t1_pending_clr", 32'(bus.pending), 32'h0);
        chk("t1_idle_busy",   32'(bus.busy),    32'h0);

        // Test 2: calls both ways, SCAN up first then reverse.
        do_reset(2'd1);
        call(4'b1001);
        tick();
        chk("t2_up", 32'(bus.command), 32'h1);
        run_until(2'b11, "t2_serve_top");
        chk("t2_top_floor",   32'(bus.cur_floor), 32'h3);
        chk("t2_top_pending", 32'(bus.pending),   32'h9);
        run_until(2'b10, "t2_down");
        chk("t2_dir_up",        32'(bus.dir_up),  32'h0);
        chk("t2_down_pending",  32'(bus.pending), 32'h1);
        run_until(2'b11, "t2_serve_bottom");
        chk("t2_bottom_floor", 32'(bus.cur_floor), 32'h0);
        run_until(2'b00, "t2_done");
        chk("t2_pending_clr", 32'(bus.pending), 32'h0);

        // Test 3: call at the current floor serves without moving.
        do_reset(2'd2);
        call(4'b0100);
        chk("t3_cmd_wait", 32'(bus.command), 32'h0);
        tick();
        chk("t3_serve_direct", 32'(bus.command),   32'h3);
        chk("t3_no_move",      32'(bus.cur_floor), 32'h2);
        run_until(2'b00, "t3_done");
        chk("t3_pending_clr", 32'(bus.pending), 32'h0);

        // Test 4: serve clear beats a same-cycle call on that floor.
        car_auto = 1'b0;
        do_reset(2'd2);
        call(4'b0100);
        tick();
        chk("t4_serve", 32'(bus.command), 32'h3);
        bus.served_pulse = 1'b1;
        bus.call_req = 4'b0101;
        tick();
        bus.served_pulse = 1'b0;
        bus.call_req = 4'b0000;
        chk("t4_clear_wins", 32'(bus.pending), 32'h1);
        chk("t4_idle",       32'(bus.command), 32'h0);
        tick();
        chk("t4_down",     32'(bus.command), 32'h2);
        chk("t4_dir_down", 32'(bus.dir_up),  32'h0);

        // Test 5: stalled move trips the watchdog.
        do_reset(2'd0);
        call(4'b0010);
        tick();
        chk("t5_up", 32'(bus.command), 32'h1);
        repeat (63) tick();
        chk("t5_no_fault_yet", 32'(bus.fault),   32'h0);
        chk("t5_still_up",     32'(bus.command), 32'h1);
        tick();
        chk("t5_fault",      32'(bus.fault),   32'h1);
        chk("t5_fault_cmd",  32'(bus.command), 32'h0);
        chk("t5_fault_busy", 32'(bus.busy),    32'h1);
        call(4'b1000);
        chk("t5_latch_in_fault", 32'(bus.pending), 32'ha);
        chk("t5_fault_sticky",   32'(bus.fault),   32'h1);
        chk("t5_fault_cmd2",     32'(bus.command), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t5_fault_cleared", 32'(bus.fault), 32'h0);

        // Test 6: asynchronous reset in the middle of a move.
        car_auto = 1'b1;
        do_reset(2'd0);
        call(4'b1010);
        tick();
        chk("t6_up", 32'(bus.command), 32'h1);
        repeat (3) tick();
        chk("t6_pending_before", 32'(bus.pending), 32'ha);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_cmd",     32'(bus.command), 32'h0);
        chk("t6_async_pending", 32'(bus.pending), 32'h0);
        chk("t6_async_busy",    32'(bus.busy),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_idle_busy", 32'(bus.busy),    32'h0);
        chk("t6_idle_cmd",  32'(bus.command), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
